// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
// Two-requester round-robin arbiter in front of one single-port RAM whose
// read address is registered, so read data appears one cycle after the
// address. One RAM instance serves both a loader and a compute core.
// Each requester issues single-word reads or writes over valid/ready. Read
// data comes back on that requester's response strobe exactly one cycle
// after acceptance.
//
// Optional feature macro: SP_RAM_ARB_INIT_CLR_EN
//   When defined, every reset is followed by a clear pass that writes zero to
//   every RAM word, with busy high and both readies held low. When it is not
//   defined, the arbiter runs straight out of reset and busy is tied low.
//
// Ports:
//   clka, rsta                    clock and synchronous active-high reset
//   reqN_valid/we/addr/wdata      requester N transaction (hold until ready)
//   reqN_ready                    requester N transaction accepted this cycle
//   rspN_valid/rdata              requester N read response (one cycle)
//   ram_addra/dina/wea            drive to the RAM port
//   ram_douta                     RAM read data (registered-address RAM)
//   busy                          init clear in progress

module sp_ram_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 72
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_dina,
   output logic              ram_wea,
   input  logic [DATA_W-1:0] ram_douta,
   output logic              busy
);

   logic              last_grant;
   logic              rsp_pend;
   logic              rsp_owner;
   logic              run;
   logic              clearing;
   logic [ADDR_W-1:0] clr_addr;
   logic              xfer;
   logic              grant_idx;
   logic              grant_we;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_wdata;

`ifdef SP_RAM_ARB_INIT_CLR_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] clr_cnt;

   always_ff @(posedge clka) begin
      if (rsta) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // The clear leaves once the last word has been written; the counter wraps
   // back to zero on that same edge, ready for the next reset.
   always_comb begin
      state_next = state;
      clearing   = 1'b0;
      run        = 1'b0;
      case (state)
         ST_CLEAR: begin
            clearing = !rsta;
            if (clr_cnt == {ADDR_W{1'b1}}) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            run = !rsta;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   assign clr_addr = clr_cnt;
`else
   assign run      = !rsta;
   assign clearing = 1'b0;
   assign clr_addr = '0;
`endif

   // Grant is combinational. Under contention the requester that did not win
   // last time is granted, which gives strict alternation. Everything is
   // gated by reset so the RAM never sees a write while rsta is high.
   always_comb begin
      grant_idx = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_idx = ~last_grant;
      end else if (req1_valid) begin
         grant_idx = 1'b1;
      end
      xfer        = run && (req0_valid || req1_valid);
      grant_we    = grant_idx ? req1_we    : req0_we;
      grant_addr  = grant_idx ? req1_addr  : req0_addr;
      grant_wdata = grant_idx ? req1_wdata : req0_wdata;
      req0_ready  = xfer && !grant_idx;
      req1_ready  = xfer && grant_idx;

      ram_wea   = 1'b0;
      ram_addra = '0;
      ram_dina  = '0;
      if (clearing) begin
         ram_wea   = 1'b1;
         ram_addra = clr_addr;
      end else if (xfer) begin
         ram_wea   = grant_we;
         ram_addra = grant_addr;
         ram_dina  = grant_we ? grant_wdata : '0;
      end
   end

   // The pointer moves only on a transfer. A read leaves a one-cycle pending
   // response tagged with its owner; the RAM output lines up with it.
   always_ff @(posedge clka) begin
      if (rsta) begin
         last_grant <= 1'b1;
         rsp_pend   <= 1'b0;
         rsp_owner  <= 1'b0;
      end else begin
         rsp_pend <= xfer && !grant_we;
         if (xfer) begin
            last_grant <= grant_idx;
            rsp_owner  <= grant_idx;
         end
      end
   end

   assign rsp0_valid = rsp_pend && !rsp_owner && !rsta;
   assign rsp1_valid = rsp_pend && rsp_owner && !rsta;
   assign rsp0_rdata = rsp0_valid ? ram_douta : '0;
   assign rsp1_rdata = rsp1_valid ? ram_douta : '0;
   assign busy       = clearing;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter
// Bench for sp_ram_arbiter: a registered-address RAM model is attached to the
// RAM port, and the expected grants, RAM drive and responses come from a
// behavioural model (a word array plus the identity of the last winner).

module tb_sp_ram_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 72;

   logic              clka = 1'b0;
   logic              rsta;
   logic              req0_valid, req0_we, req0_ready, rsp0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
   logic              req1_valid, req1_we, req1_ready, rsp1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina, ram_douta;
   logic              ram_wea, busy;

   always #5 clka = ~clka;

   sp_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clka(clka), .rsta(rsta),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
      .ram_douta(ram_douta), .busy(busy)
   );

   // Registered-address single-port RAM
   logic              mem_init;
   logic [DATA_W-1:0] mem [0:1023];
   logic [ADDR_W-1:0] addr_q;

   always @(posedge clka) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (ram_wea) begin
         mem[ram_addra] <= ram_dina;
      end
      addr_q <= ram_addra;
   end
   assign ram_douta = mem[addr_q];

   // Reference model state
   int                checks = 0;
   int                passes = 0;
   int                last_win;
   logic              exp_rv [2];
   logic [DATA_W-1:0] exp_rd;
   logic [DATA_W-1:0] ref_mem [0:1023];
   logic              pv [2];
   logic              pwe [2];
   logic [ADDR_W-1:0] pa [2];
   logic [DATA_W-1:0] pd [2];

   localparam logic [DATA_W-1:0] VAL5 = 72'h0A_5555_AAAA_1234_5678;

   function automatic int model_grant();
      if (rsta) return -1;
      if (req0_valid && req1_valid) return (last_win == 0) ? 1 : 0;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic drive(input logic v0, input logic we0, input logic [ADDR_W-1:0] a0,
                        input logic [DATA_W-1:0] d0, input logic v1, input logic we1,
                        input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      @(negedge clka);
      req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
      #1;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // Moves the model across one rising edge using the inputs currently driven.
   task automatic advance();
      int g;
      g = model_grant();
      @(posedge clka);
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (rsta) begin
         last_win = 1;
      end else if (g == 0) begin
         last_win = 0;
         if (req0_we) ref_mem[req0_addr] = req0_wdata;
         else begin exp_rv[0] = 1'b1; exp_rd = ref_mem[req0_addr]; end
      end else if (g == 1) begin
         last_win = 1;
         if (req1_we) ref_mem[req1_addr] = req1_wdata;
         else begin exp_rv[1] = 1'b1; exp_rd = ref_mem[req1_addr]; end
      end
   endtask

   task automatic release_reset();
      @(negedge clka);
      rsta = 1'b0;
      #1;
`ifdef SP_RAM_ARB_INIT_CLR_EN
      begin
         int k;
         k = 0;
         while (busy === 1'b1 && k < 2000) begin @(negedge clka); #1; k++; end
         checks++; if (busy !== 1'b0) $display("FAIL clear_timeout busy got %b want 0", busy); else passes++;
         for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      end
`endif
   endtask

   task automatic do_reset();
      @(negedge clka);
      rsta = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      advance();
      release_reset();
   endtask

   task automatic test_reset();
      @(negedge clka); #1;
      checks++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0 got %b want 0", req0_ready); else passes++;
      checks++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1 got %b want 0", req1_ready); else passes++;
      checks++; if (ram_wea !== 1'b0) $display("FAIL rst_wea got %b want 0", ram_wea); else passes++;
      checks++; if (ram_addra !== '0) $display("FAIL rst_addra got %h want 0", ram_addra); else passes++;
      checks++; if (ram_dina !== '0) $display("FAIL rst_dina got %h want 0", ram_dina); else passes++;
      checks++; if (rsp0_valid !== 1'b0) $display("FAIL rst_rsp0_valid got %b want 0", rsp0_valid); else passes++;
      checks++; if (rsp1_valid !== 1'b0) $display("FAIL rst_rsp1_valid got %b want 0", rsp1_valid); else passes++;
      checks++; if (rsp0_rdata !== '0) $display("FAIL rst_rsp0_rdata got %h want 0", rsp0_rdata); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
      advance();
      advance();
      @(negedge clka);
      mem_init = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      release_reset();
      checks++; if (busy !== 1'b0) $display("FAIL post_rst_busy got %b want 0", busy); else passes++;
   endtask

   task automatic test_single_read();
      drive(1'b1, 1'b1, 10'h005, VAL5, 1'b0, 1'b0, '0, '0);
      checks++; if (req0_ready !== 1'b1) $display("FAIL single_wr_ready0 got %b want 1", req0_ready); else passes++;
      checks++; if (ram_wea !== 1'b1) $display("FAIL single_wr_wea got %b want 1", ram_wea); else passes++;
      checks++; if (ram_addra !== 10'h005) $display("FAIL single_wr_addra got %h want 005", ram_addra); else passes++;
      checks++; if (ram_dina !== VAL5) $display("FAIL single_wr_dina got %h want %h", ram_dina, VAL5); else passes++;
      advance();
      drive(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
      checks++; if (req0_ready !== 1'b1) $display("FAIL single_rd_ready0 got %b want 1", req0_ready); else passes++;
      checks++; if (ram_wea !== 1'b0) $display("FAIL single_rd_wea got %b want 0", ram_wea); else passes++;
      checks++; if (ram_dina !== '0) $display("FAIL single_rd_dina got %h want 0", ram_dina); else passes++;
      advance();
      drive_idle();
      checks++; if (rsp0_valid !== 1'b1) $display("FAIL single_rsp0_valid got %b want 1", rsp0_valid); else passes++;
      checks++; if (rsp0_rdata !== VAL5) $display("FAIL single_rsp0_rdata got %h want %h", rsp0_rdata, VAL5); else passes++;
      checks++; if (rsp1_valid !== 1'b0) $display("FAIL single_rsp1_valid got %b want 0", rsp1_valid); else passes++;
      advance();
      drive_idle();
      checks++; if (rsp0_valid !== 1'b0) $display("FAIL single_rsp0_once got %b want 0", rsp0_valid); else passes++;
      advance();
   endtask

   task automatic test_contention();
      int g;
      int n0;
      int n1;
      logic want0;
      n0 = 0;
      n1 = 0;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i < 6) drive(1'b1, 1'b0, 10'(32 + n0), '0, 1'b1, 1'b1, 10'(32 + n1), 72'hC0DE_0000 + 72'(n1));
         else drive_idle();
         g = model_grant();
         want0 = (i > 0) && ((i - 1) % 2 == 0);
         if (i < 6) begin
            checks++; if (req0_ready !== (i % 2 == 0)) $display("FAIL cont_ready0 cyc %0d got %b want %b", i, req0_ready, (i % 2 == 0)); else passes++;
            checks++; if (req1_ready !== (i % 2 == 1)) $display("FAIL cont_ready1 cyc %0d got %b want %b", i, req1_ready, (i % 2 == 1)); else passes++;
         end
         checks++; if (rsp0_valid !== want0) $display("FAIL cont_rsp0_valid cyc %0d got %b want %b", i, rsp0_valid, want0); else passes++;
         checks++; if (rsp1_valid !== 1'b0) $display("FAIL cont_rsp1_valid cyc %0d got %b want 0", i, rsp1_valid); else passes++;
         if (want0) begin
            checks++; if (rsp0_rdata !== exp_rd) $display("FAIL cont_rsp0_rdata cyc %0d got %h want %h", i, rsp0_rdata, exp_rd); else passes++;
         end
         advance();
         if (g == 0) n0++;
         else if (g == 1) n1++;
      end
   endtask

   task automatic test_raw();
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, {DATA_W{1'b1}});
      checks++; if (req1_ready !== 1'b1) $display("FAIL raw_ready1 got %b want 1", req1_ready); else passes++;
      advance();
      drive(1'b1, 1'b0, 10'h3FF, '0, 1'b0, 1'b0, '0, '0);
      checks++; if (req0_ready !== 1'b1) $display("FAIL raw_ready0 got %b want 1", req0_ready); else passes++;
      advance();
      drive_idle();
      checks++; if (rsp0_valid !== 1'b1) $display("FAIL raw_rsp0_valid got %b want 1", rsp0_valid); else passes++;
      checks++; if (rsp0_rdata !== {DATA_W{1'b1}}) $display("FAIL raw_rsp0_rdata got %h want all-ones", rsp0_rdata); else passes++;
      advance();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 3; i++) begin
         drive_idle();
         checks++; if (ram_wea !== 1'b0) $display("FAIL idle_wea got %b want 0", ram_wea); else passes++;
         checks++; if (ram_addra !== '0) $display("FAIL idle_addra got %h want 0", ram_addra); else passes++;
         checks++; if (ram_dina !== '0) $display("FAIL idle_dina got %h want 0", ram_dina); else passes++;
         checks++; if ((req0_ready | req1_ready) !== 1'b0) $display("FAIL idle_ready got %b%b want 00", req0_ready, req1_ready); else passes++;
         advance();
      end
      // requester 0 won last (read in test_raw), so requester 1 wins now
      drive(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h3FF, '0);
      checks++; if (req1_ready !== 1'b1) $display("FAIL idle_cont_ready1 got %b want 1", req1_ready); else passes++;
      checks++; if (req0_ready !== 1'b0) $display("FAIL idle_cont_ready0 got %b want 0", req0_ready); else passes++;
      advance();
      drive_idle();
      checks++; if (rsp1_valid !== 1'b1) $display("FAIL idle_rsp1_valid got %b want 1", rsp1_valid); else passes++;
      checks++; if (rsp1_rdata !== {DATA_W{1'b1}}) $display("FAIL idle_rsp1_rdata got %h want all-ones", rsp1_rdata); else passes++;
      advance();
   endtask

   task automatic test_reset_mid_read();
      drive(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
      checks++; if (req0_ready !== 1'b1) $display("FAIL mid_rd_ready0 got %b want 1", req0_ready); else passes++;
      advance();
      @(negedge clka);
      rsta = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      checks++; if (rsp0_valid !== 1'b0) $display("FAIL mid_rst_rsp0_valid got %b want 0", rsp0_valid); else passes++;
      checks++; if (rsp0_rdata !== '0) $display("FAIL mid_rst_rsp0_rdata got %h want 0", rsp0_rdata); else passes++;
      advance();
      release_reset();
      checks++; if (rsp0_valid !== 1'b0) $display("FAIL mid_post_rsp0_valid got %b want 0", rsp0_valid); else passes++;
      drive(1'b1, 1'b0, 10'h006, '0, 1'b1, 1'b0, 10'h007, '0);
      checks++; if (req0_ready !== 1'b1) $display("FAIL mid_cont_ready0 got %b want 1", req0_ready); else passes++;
      checks++; if (req1_ready !== 1'b0) $display("FAIL mid_cont_ready1 got %b want 0", req1_ready); else passes++;
      advance();
      drive_idle();
      checks++; if (rsp0_valid !== 1'b1) $display("FAIL mid_rsp0_valid got %b want 1", rsp0_valid); else passes++;
      checks++; if (rsp0_rdata !== exp_rd) $display("FAIL mid_rsp0_rdata got %h want %h", rsp0_rdata, exp_rd); else passes++;
      advance();
   endtask

   task automatic test_random();
      int                g;
      logic              exp_wea;
      logic [ADDR_W-1:0] exp_addr;
      logic [DATA_W-1:0] exp_dina;
      logic [95:0]       r96;
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      for (int c = 0; c < 300; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pv[n] && $urandom_range(0, 3) != 0) begin
               pv[n]  = 1'b1;
               pwe[n] = 1'($urandom_range(0, 1));
               pa[n]  = 10'($urandom_range(0, 7));
               if ($urandom_range(0, 1) == 1) pa[n][9] = 1'b1;
               r96    = {$urandom, $urandom, $urandom};
               pd[n]  = r96[DATA_W-1:0];
            end
         end
         drive(pv[0], pwe[0], pa[0], pd[0], pv[1], pwe[1], pa[1], pd[1]);
         g = model_grant();
         exp_wea  = 1'b0;
         exp_addr = '0;
         exp_dina = '0;
         if (g >= 0) begin
            exp_wea  = pwe[g];
            exp_addr = pa[g];
            exp_dina = pwe[g] ? pd[g] : '0;
         end
         checks++; if (req0_ready !== (g == 0)) $display("FAIL rand_ready0 cyc %0d got %b want %b", c, req0_ready, (g == 0)); else passes++;
         checks++; if (req1_ready !== (g == 1)) $display("FAIL rand_ready1 cyc %0d got %b want %b", c, req1_ready, (g == 1)); else passes++;
         checks++; if (ram_wea !== exp_wea) $display("FAIL rand_wea cyc %0d got %b want %b", c, ram_wea, exp_wea); else passes++;
         checks++; if (ram_addra !== exp_addr) $display("FAIL rand_addra cyc %0d got %h want %h", c, ram_addra, exp_addr); else passes++;
         checks++; if (ram_dina !== exp_dina) $display("FAIL rand_dina cyc %0d got %h want %h", c, ram_dina, exp_dina); else passes++;
         checks++; if (rsp0_valid !== exp_rv[0]) $display("FAIL rand_rsp0_valid cyc %0d got %b want %b", c, rsp0_valid, exp_rv[0]); else passes++;
         checks++; if (rsp1_valid !== exp_rv[1]) $display("FAIL rand_rsp1_valid cyc %0d got %b want %b", c, rsp1_valid, exp_rv[1]); else passes++;
         checks++; if (rsp0_rdata !== (exp_rv[0] ? exp_rd : '0)) $display("FAIL rand_rsp0_rdata cyc %0d got %h want %h", c, rsp0_rdata, (exp_rv[0] ? exp_rd : '0)); else passes++;
         checks++; if (rsp1_rdata !== (exp_rv[1] ? exp_rd : '0)) $display("FAIL rand_rsp1_rdata cyc %0d got %h want %h", c, rsp1_rdata, (exp_rv[1] ? exp_rd : '0)); else passes++;
         advance();
         if (g >= 0) pv[g] = 1'b0;
      end
      drive_idle();
      advance();
   endtask

`ifdef SP_RAM_ARB_INIT_CLR_EN
   task automatic test_init_clear();
      @(negedge clka);
      rsta = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h200; req0_wdata = '0;
      req1_valid = 1'b0;
      #1;
      @(posedge clka);
      @(negedge clka);
      rsta = 1'b0;
      #1;
      for (int i = 0; i < 256; i++) begin
         checks++; if (busy !== 1'b1 || ram_wea !== 1'b1 || ram_addra !== 10'(i) || req0_ready !== 1'b0)
            $display("FAIL clr1 cyc %0d got busy %b wea %b addr %h ready0 %b want 1 1 %h 0", i, busy, ram_wea, ram_addra, req0_ready, 10'(i)); else passes++;
         @(negedge clka); #1;
      end
      rsta = 1'b1;
      #1;
      checks++; if (ram_wea !== 1'b0) $display("FAIL clr_rst_wea got %b want 0", ram_wea); else passes++;
      @(negedge clka);
      rsta = 1'b0;
      #1;
      for (int i = 0; i < 1024; i++) begin
         checks++; if (busy !== 1'b1 || ram_wea !== 1'b1 || ram_addra !== 10'(i) || ram_dina !== '0 || req0_ready !== 1'b0)
            $display("FAIL clr2 cyc %0d got busy %b wea %b addr %h ready0 %b want 1 1 %h 0", i, busy, ram_wea, ram_addra, req0_ready, 10'(i)); else passes++;
         @(negedge clka); #1;
      end
      checks++; if (busy !== 1'b0) $display("FAIL clr_done_busy got %b want 0", busy); else passes++;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      last_win = 1;
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      checks++; if (req0_ready !== 1'b1) $display("FAIL clr_rd_ready0 got %b want 1", req0_ready); else passes++;
      advance();
      drive_idle();
      checks++; if (rsp0_valid !== 1'b1) $display("FAIL clr_rsp0_valid got %b want 1", rsp0_valid); else passes++;
      checks++; if (rsp0_rdata !== '0) $display("FAIL clr_rsp0_rdata got %h want 0", rsp0_rdata); else passes++;
      advance();
   endtask
`endif

   initial begin
      rsta = 1'b1;
      mem_init = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h001; req0_wdata = '1;
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'h002; req1_wdata = '1;
      last_win = 1;
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      exp_rd = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      test_reset();
      test_single_read();
      test_contention();
      test_raw();
      test_idle();
      test_reset_mid_read();
      test_random();
`ifdef SP_RAM_ARB_INIT_CLR_EN
      test_init_clear();
`endif
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0d of %0d checks", passes, checks);
      $fatal(1, "[TB] watchdog");
   end

endmodule
